// File: rtl/rf_pkg.sv
// Shared definitions for the parameterised register file.
// Holds the parameter defaults and the PC-update priority encoding so that
// the top module and any tooling agree on which source wins at a clock edge.
package rf_pkg;

    localparam int unsigned RF_DATA_W_DEF  = 32;
    localparam int unsigned RF_ADDR_W_DEF  = 4;
    localparam int unsigned RF_NUM_RD_DEF  = 3;
    localparam int unsigned RF_PC_STEP_DEF = 4;
    localparam int unsigned RF_BYPASS_DEF  = 1;

    // PC update source, ordered so a higher code means a higher priority
    typedef enum logic [1:0] {
        PC_HOLD    = 2'd0,
        PC_STEP_UP = 2'd1,
        PC_GEN_WR  = 2'd2,
        PC_LOAD    = 2'd3
    } pc_sel_e;

    // Priority: explicit load > general write to PC > increment > hold
    function automatic pc_sel_e pc_select(input logic loadpc,
                                          input logic wr_hit,
                                          input logic inc);
        pc_sel_e sel;
        sel = PC_HOLD;
        if (loadpc) begin
            sel = PC_LOAD;
        end else if (wr_hit) begin
            sel = PC_GEN_WR;
        end else if (inc) begin
            sel = PC_STEP_UP;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Ports:
//   rd_addr   - register index to read
//   regs      - current register contents
//   busy      - per-register pending-load flags
//   fwd_en    - a general write is in flight this cycle (already gated by reset)
//   wr_addr   - index of the in-flight write
//   wr_data   - data of the in-flight write
//   rd_data_c - read data (forwarded from the write when BYPASS != 0)
//   rd_busy_c - pending-load flag of the addressed register (never forwarded)
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W_DEF,
    parameter int unsigned ADDR_W = RF_ADDR_W_DEF,
    parameter int unsigned BYPASS = RF_BYPASS_DEF,
    localparam int unsigned DEPTH = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0]  busy,
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              rd_busy_c
);

    // Stored value, optionally replaced by same-cycle write data
    always_comb begin
        rd_data_c = regs[rd_addr];
        rd_busy_c = busy[rd_addr];
        if ((BYPASS != 0) && fwd_en && (wr_addr == rd_addr)) begin
            rd_data_c = wr_data;
        end
    end

endmodule

// File: rtl/register_file_param.sv
// Parameterised register file with an embedded program counter and a
// pending-load scoreboard.
// Ports:
//   Clk, RESET       - clock; asynchronous active-high reset
//   Rd, Mem          - ALU result / memory load write data
//   WR_EN, WR_SRC    - write enable; source select (0 = Rd, 1 = Mem)
//   WR_ADDR          - write index
//   RD_ADDR          - packed read indices, NUM_RD ports
//   Pcin, LOADPC     - PC load value and load strobe
//   PC_INC           - advance PC by PC_STEP
//   LD_REQ, LD_ADDR  - mark a register as waiting for a memory load
//   RD_DATA, RD_BUSY - packed combinational read data and busy flags
//   PCout            - current PC register value
module register_file_param
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W  = RF_DATA_W_DEF,
    parameter int unsigned ADDR_W  = RF_ADDR_W_DEF,
    parameter int unsigned NUM_RD  = RF_NUM_RD_DEF,
    parameter int unsigned PC_IDX  = (1 << ADDR_W) - 1,
    parameter int unsigned PC_STEP = RF_PC_STEP_DEF,
    parameter int unsigned BYPASS  = RF_BYPASS_DEF
) (
    input  logic                     Clk,
    input  logic                     RESET,
    input  logic [DATA_W-1:0]        Rd,
    input  logic [DATA_W-1:0]        Mem,
    input  logic                     WR_EN,
    input  logic                     WR_SRC,
    input  logic [ADDR_W-1:0]        WR_ADDR,
    input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
    input  logic [DATA_W-1:0]        Pcin,
    input  logic                     LOADPC,
    input  logic                     PC_INC,
    input  logic                     LD_REQ,
    input  logic [ADDR_W-1:0]        LD_ADDR,
    output logic [NUM_RD*DATA_W-1:0] RD_DATA,
    output logic [NUM_RD-1:0]        RD_BUSY,
    output logic [DATA_W-1:0]        PCout
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [DATA_W-1:0] wr_data;
    logic              wr_pc_hit;
    logic              fwd_en;

    assign wr_data   = WR_SRC ? Mem : Rd;
    assign wr_pc_hit = WR_EN && (WR_ADDR == PC_A);
    // Forwarding is suppressed during reset so reads stay at zero
    assign fwd_en    = WR_EN && !RESET;

    // Next-state for storage, PC and scoreboard
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;

        if (WR_EN && !wr_pc_hit) begin
            regs_d[WR_ADDR] = wr_data;
        end

        case (pc_select(LOADPC, wr_pc_hit, PC_INC))
            PC_LOAD:    regs_d[PC_A] = Pcin;
            PC_GEN_WR:  regs_d[PC_A] = wr_data;
            PC_STEP_UP: regs_d[PC_A] = regs_q[PC_A] + DATA_W'(PC_STEP);
            default:    regs_d[PC_A] = regs_q[PC_A];
        endcase

        // Load completion clears first so a same-edge new request wins
        if (WR_EN && WR_SRC) begin
            busy_d[WR_ADDR] = 1'b0;
        end
        if (LD_REQ) begin
            busy_d[LD_ADDR] = 1'b1;
        end
        busy_d[PC_A] = 1'b0;
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign PCout = regs_q[PC_A];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rd_port (
            .rd_addr   (RD_ADDR[k*ADDR_W +: ADDR_W]),
            .regs      (regs_q),
            .busy      (busy_q),
            .fwd_en    (fwd_en),
            .wr_addr   (WR_ADDR),
            .wr_data   (wr_data),
            .rd_data_c (RD_DATA[k*DATA_W +: DATA_W]),
            .rd_busy_c (RD_BUSY[k])
        );
    end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a default build (32-bit, 3 ports, forwarding)
// and a 16-bit, 5-port, read-old build share one stimulus stream.
module tb_register_file_param;

    typedef struct {
        logic [95:0] rda;
        logic [2:0]  bsa;
        logic [31:0] pca;
        logic [79:0] rdb;
        logic [4:0]  bsb;
        logic [15:0] pcb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] rd, mem, pcin;
    logic        wr_en, wr_src, loadpc, pc_inc, ld_req;
    logic [3:0]  wr_addr, ld_addr;
    logic [3:0]  ra [5];
    logic [11:0] rd_addr_a;
    logic [19:0] rd_addr_b;

    logic [95:0] rdata_a;
    logic [2:0]  rbusy_a;
    logic [31:0] pc_a;
    logic [79:0] rdata_b;
    logic [4:0]  rbusy_b;
    logic [15:0] pc_b;

    always_comb begin
        rd_addr_a = {ra[2], ra[1], ra[0]};
        rd_addr_b = {ra[4], ra[3], ra[2], ra[1], ra[0]};
    end

    register_file_param dut_a (
        .Clk(clk), .RESET(rst), .Rd(rd), .Mem(mem), .WR_EN(wr_en), .WR_SRC(wr_src),
        .WR_ADDR(wr_addr), .RD_ADDR(rd_addr_a), .Pcin(pcin), .LOADPC(loadpc),
        .PC_INC(pc_inc), .LD_REQ(ld_req), .LD_ADDR(ld_addr),
        .RD_DATA(rdata_a), .RD_BUSY(rbusy_a), .PCout(pc_a)
    );

    register_file_param #(.DATA_W(16), .NUM_RD(5), .BYPASS(0)) dut_b (
        .Clk(clk), .RESET(rst), .Rd(rd[15:0]), .Mem(mem[15:0]), .WR_EN(wr_en),
        .WR_SRC(wr_src), .WR_ADDR(wr_addr), .RD_ADDR(rd_addr_b), .Pcin(pcin[15:0]),
        .LOADPC(loadpc), .PC_INC(pc_inc), .LD_REQ(ld_req), .LD_ADDR(ld_addr),
        .RD_DATA(rdata_b), .RD_BUSY(rbusy_b), .PCout(pc_b)
    );

    // Reference state: register contents per build, shared busy set
    logic [31:0] m_a [16];
    logic [15:0] m_b [16];
    logic [15:0] m_busy;

    int   total = 0;
    int   bad   = 0;
    exp_t q [$];
    event present;

    function automatic void clear_model();
        for (int i = 0; i < 16; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_busy = '0;
    endfunction

    function automatic exp_t predict();
        exp_t        e;
        logic [31:0] wd;
        wd = wr_src ? mem : rd;
        for (int k = 0; k < 3; k++) begin
            e.rda[k*32 +: 32] = (!rst && wr_en && wr_addr == ra[k]) ? wd : m_a[ra[k]];
            e.bsa[k] = m_busy[ra[k]];
        end
        for (int k = 0; k < 5; k++) begin
            e.rdb[k*16 +: 16] = m_b[ra[k]];
            e.bsb[k] = m_busy[ra[k]];
        end
        e.pca = m_a[15];
        e.pcb = m_b[15];
        return e;
    endfunction

    // Apply one rising edge to the reference using the inputs present at it
    function automatic void model_edge();
        logic [31:0] wd, npa;
        logic [15:0] npb;
        if (rst) begin
            clear_model();
            return;
        end
        wd  = wr_src ? mem : rd;
        npa = m_a[15];
        npb = m_b[15];
        if (loadpc) begin
            npa = pcin;
            npb = pcin[15:0];
        end else if (wr_en && wr_addr == 4'd15) begin
            npa = wd;
            npb = wd[15:0];
        end else if (pc_inc) begin
            npa = m_a[15] + 32'd4;
            npb = m_b[15] + 16'd4;
        end
        if (wr_en && wr_addr != 4'd15) begin
            m_a[wr_addr] = wd;
            m_b[wr_addr] = wd[15:0];
        end
        m_a[15] = npa;
        m_b[15] = npb;
        if (wr_en && wr_src) m_busy[wr_addr] = 1'b0;
        if (ld_req && ld_addr != 4'd15) m_busy[ld_addr] = 1'b1;
    endfunction

    task automatic idle();
        wr_en = 1'b0; wr_src = 1'b0; loadpc = 1'b0; pc_inc = 1'b0; ld_req = 1'b0;
    endtask

    task automatic set_ra(input logic [3:0] a);
        for (int k = 0; k < 5; k++) ra[k] = a;
    endtask

    task automatic check_now();
        q.push_back(predict());
        -> present;
        #2;
    endtask

    task automatic step();
        check_now();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic pulse_reset();
        rst = 1'b1;
        clear_model();
        check_now();
    endtask

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation each time outputs are presented
    initial begin
        exp_t e;
        forever begin
            @(present);
            #1;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries want 1", $time);
            end else begin
                e = q.pop_front();
                chk("rd_data_a", 96'(rdata_a), 96'(e.rda));
                chk("rd_busy_a", 96'(rbusy_a), 96'(e.bsa));
                chk("pcout_a",   96'(pc_a),    96'(e.pca));
                chk("rd_data_b", 96'(rdata_b), 96'(e.rdb));
                chk("rd_busy_b", 96'(rbusy_b), 96'(e.bsb));
                chk("pcout_b",   96'(pc_b),    96'(e.pcb));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd = '0; mem = '0; pcin = '0; wr_addr = '0; ld_addr = '0;
        idle();
        set_ra(4'd0);
        clear_model();
        #3;
        check_now();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write with forwarding vs read-old, then the committed value
        ra[0] = 4'd2; wr_en = 1'b1; wr_src = 1'b0; rd = 32'd1; wr_addr = 4'd2;
        step();
        idle();
        step();

        // PC priority, increment and wrap
        ra[1] = 4'd15;
        loadpc = 1'b1; pcin = 32'd100; pc_inc = 1'b1; wr_en = 1'b1; wr_addr = 4'd15; rd = 32'd7;
        step();
        idle(); pc_inc = 1'b1;
        step();
        idle(); loadpc = 1'b1; pcin = 32'hFFFF_FFFC;
        step();
        idle(); pc_inc = 1'b1;
        step();
        idle();
        step();

        // Pending load: Rd write keeps busy, Mem write clears it
        ld_req = 1'b1; ld_addr = 4'd5;
        step();
        idle(); set_ra(4'd5); rd = 32'd33; wr_en = 1'b1; wr_addr = 4'd5;
        step();
        idle(); mem = 32'd9; wr_src = 1'b1; wr_en = 1'b1; wr_addr = 4'd5;
        step();
        idle();
        step();

        // Same-edge request and completion; request on PC is ignored
        set_ra(4'd3);
        ld_req = 1'b1; ld_addr = 4'd3; wr_en = 1'b1; wr_src = 1'b1; mem = 32'h55; wr_addr = 4'd3;
        step();
        idle();
        step();
        set_ra(4'd15); ld_req = 1'b1; ld_addr = 4'd15;
        step();
        idle();
        step();

        // Mid-cycle reset with active controls that must be ignored
        pulse_reset();
        wr_en = 1'b1; wr_addr = 4'd6; rd = 32'h1234; loadpc = 1'b1; pcin = 32'd44;
        ld_req = 1'b1; ld_addr = 4'd4; ra[0] = 4'd6;
        step();
        step();
        rst = 1'b0;
        idle();
        step();

        // Fill every register with a distinct value, then read all on every port
        for (int i = 0; i < 16; i++) begin
            idle(); wr_en = 1'b1; wr_addr = 4'(i);
            rd = 32'hA5A5_0000 | 32'(16'h1000 + 16'(i) * 16'h0111);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            for (int k = 0; k < 5; k++) ra[k] = 4'((i + k) % 16);
            step();
        end

        // Randomised traffic, with one asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            rd      = $urandom;
            mem     = $urandom;
            pcin    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            wr_en   = 1'($urandom_range(0, 1));
            wr_src  = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            loadpc  = ($urandom_range(0, 15) == 0);
            pc_inc  = 1'($urandom_range(0, 1));
            ld_req  = ($urandom_range(0, 2) == 0);
            ld_addr = 4'($urandom_range(0, 15));
            for (int k = 0; k < 5; k++) begin
                ra[k] = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            end
            if (n == 200) begin
                pulse_reset();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        idle();
        #5;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL take parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL take parameter ADDR_W, default 4: register index width; the file has DEPTH = 2**ADDR_W registers.
REQ-003 SHALL take parameter NUM_RD, default 3: number of combinational read ports.
REQ-004 SHALL take parameter PC_IDX, default DEPTH-1: index of the register that acts as the program counter.
REQ-005 SHALL take parameter PC_STEP, default 4: PC auto-increment amount.
REQ-006 SHALL take parameter BYPASS, default 1: 1 = write-first forwarding on read ports, 0 = read-old.
REQ-007 Port Clk  in  1: single clock; all state updates on its rising edge.
REQ-008 Port RESET  in  1: reset, asynchronous and active-high.
REQ-009 Port Rd  in  DATA_W: ALU result write data.
REQ-010 Port Mem  in  DATA_W: memory load write data.
REQ-011 Port WR_EN  in  1: general write enable.
REQ-012 Port WR_SRC  in  1: 0 = write Rd, 1 = write Mem.
REQ-013 Port WR_ADDR  in  ADDR_W: write target index.
REQ-014 Port RD_ADDR  in  NUM_RD*ADDR_W: packed read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-015 Port Pcin  in  DATA_W: PC load value.
REQ-016 Port LOADPC  in  1: load PC from Pcin.
REQ-017 Port PC_INC  in  1: increment PC by PC_STEP.
REQ-018 Port LD_REQ  in  1: mark register LD_ADDR pending a memory load.
REQ-019 Port LD_ADDR  in  ADDR_W: index marked by LD_REQ.
REQ-020 Port RD_DATA  out  NUM_RD*DATA_W: packed read data, same packing as RD_ADDR.
REQ-021 Port RD_BUSY  out  NUM_RD: per-port flag, addressed register has a pending load.
REQ-022 Port PCout  out  DATA_W: current PC register value.

Function
REQ-023 Reads SHALL be combinational: RD_DATA[k] = reg[RD_ADDR[k]], zero-cycle latency.
REQ-024 With BYPASS=1, a read port addressing WR_ADDR while WR_EN=1 SHALL return the selected write data in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-025 WR_EN=1 SHALL write (WR_SRC ? Mem : Rd) to reg[WR_ADDR] at the rising edge; one-cycle write latency.
REQ-026 PC update priority at an edge: LOADPC (Pcin) > WR_EN with WR_ADDR==PC_IDX > PC_INC (PC+PC_STEP) > hold.
REQ-027 PC increment SHALL wrap modulo 2**DATA_W; no carry or overflow output.
REQ-028 PCout SHALL equal reg[PC_IDX] at all times; reads of PC_IDX return the same value, forwarded per REQ-024 only for general writes.
REQ-029 Scoreboard: LD_REQ=1 SHALL set busy[LD_ADDR] at the edge; WR_EN=1 with WR_SRC=1 SHALL clear busy[WR_ADDR].
REQ-030 Same-edge LD_REQ and Mem write to the same index: busy SHALL end set (new request wins).
REQ-031 Rd writes (WR_SRC=0) SHALL NOT change busy bits.
REQ-032 RD_BUSY[k] = busy[RD_ADDR[k]], combinational, not bypassed.
REQ-033 LD_REQ on PC_IDX SHALL be ignored; busy[PC_IDX] is always 0.
REQ-034 X/Z on data inputs SHALL only propagate to the register written; control inputs are assumed driven.

Reset
REQ-035 RESET high SHALL immediately clear all registers, PC and busy bits to 0, regardless of Clk.
REQ-036 While RESET is high, RD_DATA = 0, RD_BUSY = 0, PCout = 0, and writes, LOADPC, PC_INC and LD_REQ SHALL be ignored.
REQ-037 The first update SHALL occur on the first rising Clk edge after RESET deasserts.

Structure
REQ-038 Parameter defaults and the PC-priority encoding SHALL live in shared package rf_pkg.
REQ-039 One sub-module, rf_read_port (mux plus bypass compare, one read port), SHALL be instantiated NUM_RD times.
REQ-040 Storage, PC logic and scoreboard SHALL stay in the top module; no memory macro inference is required.

Verification
REQ-041 RESET pulse mid-run, asynchronous to Clk -> all outputs 0 within the same timestep, before any edge.
REQ-042 WR_EN=1, WR_SRC=0, Rd=1, WR_ADDR=2, RD_ADDR port0=2 -> port0 reads 1 before the edge (BYPASS=1) and 1 after the edge; with BYPASS=0 it reads 0 before the edge.
REQ-043 LOADPC=1, Pcin=100, PC_INC=1 and WR_EN to PC_IDX with Rd=7 on the same edge -> PCout=100; then PC_INC only -> 104; Pcin=32'hFFFFFFFC then PC_INC -> 0.
REQ-044 LD_REQ on LD_ADDR=5 -> RD_BUSY=1 for any port reading 5; Rd write to 5 -> still busy; Mem=9 write to 5 -> busy 0, data 9.
REQ-045 LD_REQ and a Mem write to index 3 on the same edge -> busy[3]=1 and reg[3]=Mem; LD_REQ on PC_IDX -> RD_BUSY stays 0.
REQ-046 NUM_RD=5, DATA_W=16 build: all 16 registers written with distinct values -> each port returns the correct value for every index.
